// File: rtl/game_reaction_multi.sv
// Multi-button reaction game: a random wait, then a target is shown and the player presses the matching button.
// Optional macro GAME_REACTION_TIMEOUT_EN ends an unanswered SHOW after TIMEOUT cycles.
`timescale 1ns/1ps
module game_reaction_multi #(
  parameter int NUM_BTNS    = 4,
  parameter int ROUNDS      = 5,
  parameter int DELAY_BASE  = 10_000_000,
  parameter int DELAY_STEP  = 10_000_000,
  parameter int RESULT_TIME = 10_000_000,
  parameter int TIMEOUT     = 20_000_000,
  parameter int CNT_W       = 28
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_BTNS-1:0] btn,
  input  logic [3:0]          rnd,
  output logic [3:0]          value,
  output logic [3:0]          score,
  output logic [CNT_W-1:0]    reaction_time,
  output logic                game_over
);

  typedef enum logic [1:0] {ST_WAIT, ST_SHOW, ST_RESULT, ST_GAME_OVER} state_e;

  localparam logic [3:0] V_BLANK   = 4'd0;
  localparam logic [3:0] V_RIGHT   = 4'd10;
  localparam logic [3:0] V_WRONG   = 4'd11;
  localparam logic [3:0] V_FALSE   = 4'd12;
  localparam logic [CNT_W-1:0] RESULT_LAST = CNT_W'(RESULT_TIME - 1);

`ifdef GAME_REACTION_TIMEOUT_EN
  localparam logic [3:0]       V_TIMEOUT    = 4'd13;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    delay_lim_q, delay_lim_d;
  logic [3:0]          target_q, target_d;
  logic [3:0]          value_q, value_d;
  logic [3:0]          score_q, score_d;
  logic [3:0]          round_q, round_d;
  logic [CNT_W-1:0]    rt_q, rt_d;
  logic                go_q, go_d;
  logic [NUM_BTNS-1:0] btn_q, btn_d;

  logic [NUM_BTNS-1:0] press;
  logic [NUM_BTNS-1:0] tgt_mask;
  logic [CNT_W-1:0]    new_lim;
  logic [3:0]          new_target;

  assign press      = btn & ~btn_q;
  assign tgt_mask   = NUM_BTNS'(1) << (target_q - 4'd1);
  assign new_lim    = CNT_W'(DELAY_BASE) + CNT_W'(rnd) * CNT_W'(DELAY_STEP);
  assign new_target = (rnd % 4'(NUM_BTNS)) + 4'd1;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    delay_lim_d = delay_lim_q;
    target_d    = target_q;
    value_d     = value_q;
    score_d     = score_q;
    round_d     = round_q;
    rt_d        = rt_q;
    go_d        = go_q;
    btn_d       = btn;

    case (state_q)
      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (|press) begin
          state_d = ST_RESULT;
          cnt_d   = '0;
          value_d = V_FALSE;
        end else if (cnt_q == delay_lim_q - CNT_W'(1)) begin
          state_d  = ST_SHOW;
          cnt_d    = '0;
          target_d = new_target;
          value_d  = new_target;
        end
      end

      ST_SHOW: begin
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        // Only a press on exactly the target bit counts; any extra bit makes it wrong.
        if (press == tgt_mask) begin
          state_d = ST_RESULT;
          cnt_d   = '0;
          value_d = V_RIGHT;
          rt_d    = cnt_q;
          if (score_q != 4'(ROUNDS)) score_d = score_q + 4'd1;
        end else if (|press) begin
          state_d = ST_RESULT;
          cnt_d   = '0;
          value_d = V_WRONG;
        end
`ifdef GAME_REACTION_TIMEOUT_EN
        else if (cnt_q == TIMEOUT_LAST) begin
          state_d = ST_RESULT;
          cnt_d   = '0;
          value_d = V_TIMEOUT;
        end
`endif
      end

      ST_RESULT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == RESULT_LAST) begin
          cnt_d   = '0;
          round_d = round_q + 4'd1;
          if (round_q + 4'd1 == 4'(ROUNDS)) begin
            state_d = ST_GAME_OVER;
            value_d = score_q;
            go_d    = 1'b1;
          end else begin
            state_d     = ST_WAIT;
            delay_lim_d = new_lim;
            value_d     = V_BLANK;
          end
        end
      end

      ST_GAME_OVER: begin
        if (|press) begin
          state_d     = ST_WAIT;
          cnt_d       = '0;
          delay_lim_d = new_lim;
          score_d     = '0;
          round_d     = '0;
          value_d     = V_BLANK;
          go_d        = 1'b0;
        end
      end

      default: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
        value_d = V_BLANK;
        go_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_WAIT;
      cnt_q       <= '0;
      delay_lim_q <= CNT_W'(DELAY_BASE);
      target_q    <= '0;
      value_q     <= V_BLANK;
      score_q     <= '0;
      round_q     <= '0;
      rt_q        <= '0;
      go_q        <= 1'b0;
      // All-ones so buttons held through reset release are not seen as presses.
      btn_q       <= '1;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling the pre-edge values.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      delay_lim_q <= delay_lim_d;
      target_q    <= target_d;
      value_q     <= value_d;
      score_q     <= score_d;
      round_q     <= round_d;
      rt_q        <= rt_d;
      go_q        <= go_d;
      btn_q       <= btn_d;
    end
  end

  assign value         = value_q;
  assign score         = score_q;
  assign reaction_time = rt_q;
  assign game_over     = go_q;

endmodule
